// File: rtl/gg_cheat_engine.sv
// Game Genie cheat table: inserts strobed codes into a slot table and patches
// ROM read data on an address (and optional compare byte) match.
module gg_cheat_engine #(
  parameter int MAX_CODES = 32,
  parameter int ADDR_W    = 16
) (
  input  logic                             clk_sys,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [128:0]                     code,
  input  logic [ADDR_W-1:0]                addr_in,
  input  logic [7:0]                       data_in,
  output logic [7:0]                       data_out,
  output logic                             genie_ovr,
  output logic                             available,
  output logic                             busy,
  output logic                             dropped,
  output logic [$clog2(MAX_CODES+1)-1:0]   code_count
);

  localparam int CW = $clog2(MAX_CODES + 1);
  localparam int IW = (MAX_CODES > 1) ? $clog2(MAX_CODES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t              state_r;
  logic [IW-1:0]       idx_r;
  logic [IW-1:0]       target_r;
  logic                new_slot_r;
  logic [CW-1:0]       code_count_r;
  logic                busy_r;
  logic                available_r;
  logic                dropped_r;
  logic [7:0]          data_out_r;
  logic                genie_ovr_r;

  logic [ADDR_W-1:0]   hold_addr_r;
  logic                hold_cmp_en_r;
  logic [7:0]          hold_cmp_r;
  logic [7:0]          hold_repl_r;

  logic                slot_valid_r  [MAX_CODES];
  logic                slot_cmp_en_r [MAX_CODES];
  logic [ADDR_W-1:0]   slot_addr_r   [MAX_CODES];
  logic [7:0]          slot_cmp_r    [MAX_CODES];
  logic [7:0]          slot_repl_r   [MAX_CODES];

  logic [MAX_CODES-1:0] slot_hit_s;
  logic                 hit_s;
  logic [7:0]           hit_repl_s;
  logic                 unused_s;

  assign unused_s = ^{code[127:97], code[95:64], code[63:40], code[31:8]};

  // Insertion FSM, slot table writes and status registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      idx_r         <= '0;
      target_r      <= '0;
      new_slot_r    <= 1'b0;
      code_count_r  <= '0;
      busy_r        <= 1'b0;
      available_r   <= 1'b0;
      dropped_r     <= 1'b0;
      hold_addr_r   <= '0;
      hold_cmp_en_r <= 1'b0;
      hold_cmp_r    <= 8'h00;
      hold_repl_r   <= 8'h00;
      for (int i = 0; i < MAX_CODES; i++) begin
        slot_valid_r[i]  <= 1'b0;
        slot_cmp_en_r[i] <= 1'b0;
        slot_addr_r[i]   <= '0;
        slot_cmp_r[i]    <= 8'h00;
        slot_repl_r[i]   <= 8'h00;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (code[128]) begin
            hold_addr_r   <= code[64 +: ADDR_W];
            hold_cmp_en_r <= code[96];
            hold_cmp_r    <= code[39:32];
            hold_repl_r   <= code[7:0];
            idx_r         <= '0;
            state_r       <= ST_SCAN;
            busy_r        <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (code[128]) begin
            dropped_r <= 1'b1;
          end
          if (slot_valid_r[idx_r] && (slot_addr_r[idx_r] == hold_addr_r)) begin
            target_r   <= idx_r;
            new_slot_r <= 1'b0;
            state_r    <= ST_WRITE;
          end else if (idx_r == IW'(MAX_CODES - 1)) begin
            if (code_count_r < CW'(MAX_CODES)) begin
              target_r   <= IW'(code_count_r);
              new_slot_r <= 1'b1;
              state_r    <= ST_WRITE;
            end else begin
              dropped_r <= 1'b1;
              state_r   <= ST_IDLE;
              busy_r    <= 1'b0;
            end
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        ST_WRITE: begin
          if (code[128]) begin
            dropped_r <= 1'b1;
          end
          slot_valid_r[target_r]  <= 1'b1;
          slot_cmp_en_r[target_r] <= hold_cmp_en_r;
          slot_addr_r[target_r]   <= hold_addr_r;
          slot_cmp_r[target_r]    <= hold_cmp_r;
          slot_repl_r[target_r]   <= hold_repl_r;
          code_count_r            <= code_count_r + (new_slot_r ? CW'(1) : CW'(0));
          available_r             <= 1'b1;
          state_r                 <= ST_IDLE;
          busy_r                  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Parallel slot compare; the descending sweep leaves the lowest hitting slot's byte.
  always_comb begin
    slot_hit_s = '0;
    hit_repl_s = 8'h00;
    for (int i = 0; i < MAX_CODES; i++) begin
      slot_hit_s[i] = slot_valid_r[i] && (slot_addr_r[i] == addr_in) &&
                      (!slot_cmp_en_r[i] || (data_in == slot_cmp_r[i]));
    end
    for (int i = MAX_CODES - 1; i >= 0; i--) begin
      hit_repl_s = slot_hit_s[i] ? slot_repl_r[i] : hit_repl_s;
    end
    hit_s = |slot_hit_s;
  end

  // Registered patched data path.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      data_out_r  <= 8'h00;
      genie_ovr_r <= 1'b0;
    end else if (enable && hit_s) begin
      data_out_r  <= hit_repl_s;
      genie_ovr_r <= 1'b1;
    end else begin
      data_out_r  <= data_in;
      genie_ovr_r <= 1'b0;
    end
  end

  assign data_out   = data_out_r;
  assign genie_ovr  = genie_ovr_r;
  assign available  = available_r;
  assign busy       = busy_r;
  assign dropped    = dropped_r;
  assign code_count = code_count_r;

endmodule

// File: tb/tb_gg_cheat_engine.sv
// Directed bench for gg_cheat_engine: reset, lookup vectors, overwrite,
// drop-on-busy, full table and reset during an insertion.
module tb_gg_cheat_engine;

  localparam int N  = 32;
  localparam int CW = $clog2(N + 1);

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          enable;
  logic [128:0]  code;
  logic [15:0]   addr_in;
  logic [7:0]    data_in;
  logic [7:0]    data_out;
  logic          genie_ovr;
  logic          available;
  logic          busy;
  logic          dropped;
  logic [CW-1:0] code_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  din;
    logic        en;
    logic [7:0]  exp_dout;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs [8];

  gg_cheat_engine #(.MAX_CODES(N), .ADDR_W(16)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .enable     (enable),
    .code       (code),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .data_out   (data_out),
    .genie_ovr  (genie_ovr),
    .available  (available),
    .busy       (busy),
    .dropped    (dropped),
    .code_count (code_count)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [15:0] a, input logic ce, input logic [7:0] c,
                       input logic [7:0] r);
    code = {1'b1, 31'd0, ce, 16'h0000, a, 24'h000000, c, 24'h000000, r};
    tick();
    code = '0;
  endtask

  task automatic wait_done();
    repeat (N + 1) tick();
    chk("busy_after_insert", 32'(busy), 32'd0);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] d, input logic en);
    addr_in = a;
    data_in = d;
    enable  = en;
    tick();
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b1;
    code    = '0;
    addr_in = 16'h1234;
    data_in = 8'h55;
    tick();
    tick();
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_genie_ovr", 32'(genie_ovr), 32'd0);
    chk("rst_available", 32'(available), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    chk("rst_count", 32'(code_count), 32'd0);
    reset = 1'b0;

    // 1: empty table passes through
    rd(16'h1234, 8'h55, 1'b1);
    chk("t1_dout", 32'(data_out), 32'h55);
    chk("t1_ovr", 32'(genie_ovr), 32'd0);

    // 2 and 3: load two codes
    pulse(16'h1234, 1'b0, 8'h00, 8'hAA);
    wait_done();
    chk("t2_count", 32'(code_count), 32'd1);
    chk("t2_available", 32'(available), 32'd1);
    pulse(16'h2000, 1'b1, 8'h10, 8'h20);
    wait_done();
    chk("t3_count", 32'(code_count), 32'd2);
    chk("t3_dropped", 32'(dropped), 32'd0);

    vecs[0] = '{16'h1234, 8'h55, 1'b1, 8'hAA, 1'b1};
    vecs[1] = '{16'h1234, 8'h55, 1'b0, 8'h55, 1'b0};
    vecs[2] = '{16'h1234, 8'h77, 1'b1, 8'hAA, 1'b1};
    vecs[3] = '{16'h2000, 8'h10, 1'b1, 8'h20, 1'b1};
    vecs[4] = '{16'h2000, 8'h11, 1'b1, 8'h11, 1'b0};
    vecs[5] = '{16'h2000, 8'h10, 1'b0, 8'h10, 1'b0};
    vecs[6] = '{16'h1235, 8'h66, 1'b1, 8'h66, 1'b0};
    vecs[7] = '{16'h3000, 8'h99, 1'b1, 8'h99, 1'b0};
    for (int i = 0; i < 8; i++) begin
      rd(vecs[i].addr, vecs[i].din, vecs[i].en);
      chk($sformatf("vec%0d_dout", i), 32'(data_out), 32'(vecs[i].exp_dout));
      chk($sformatf("vec%0d_ovr", i), 32'(genie_ovr), 32'(vecs[i].exp_ovr));
    end

    // Exact insertion latency: still pass-through on the WRITE edge, patched one read later
    addr_in = 16'h4000;
    data_in = 8'h33;
    enable  = 1'b1;
    pulse(16'h4000, 1'b0, 8'h00, 8'h44);
    repeat (N) tick();
    chk("lat_busy_before_write", 32'(busy), 32'd1);
    chk("lat_ovr_before_write", 32'(genie_ovr), 32'd0);
    tick();
    chk("lat_busy_done", 32'(busy), 32'd0);
    chk("lat_count", 32'(code_count), 32'd3);
    chk("lat_ovr_on_write", 32'(genie_ovr), 32'd0);
    chk("lat_dout_on_write", 32'(data_out), 32'h33);
    tick();
    chk("lat_ovr_after", 32'(genie_ovr), 32'd1);
    chk("lat_dout_after", 32'(data_out), 32'h44);

    // 4: overwrite keeps count
    pulse(16'h1234, 1'b0, 8'h00, 8'hBB);
    wait_done();
    chk("t4_count", 32'(code_count), 32'd3);
    rd(16'h1234, 8'h55, 1'b1);
    chk("t4_dout", 32'(data_out), 32'hBB);

    // 4b: second strobe while scanning is dropped
    pulse(16'h5000, 1'b0, 8'h00, 8'h50);
    tick();
    tick();
    pulse(16'h6000, 1'b0, 8'h00, 8'h60);
    wait_done();
    chk("t4b_dropped", 32'(dropped), 32'd1);
    chk("t4b_count", 32'(code_count), 32'd4);
    rd(16'h5000, 8'h01, 1'b1);
    chk("t4b_first_dout", 32'(data_out), 32'h50);
    rd(16'h6000, 8'h02, 1'b1);
    chk("t4b_second_dout", 32'(data_out), 32'h02);
    chk("t4b_second_ovr", 32'(genie_ovr), 32'd0);

    // 5: fill the table, then overflow
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      pulse(16'h8000 + 16'(i), 1'b0, 8'h00, 8'(i + 1));
      wait_done();
    end
    chk("t5_count_full", 32'(code_count), 32'(N));
    chk("t5_dropped_before", 32'(dropped), 32'd0);
    rd(16'h8000 + 16'(N - 1), 8'hF0, 1'b1);
    chk("t5_last_slot", 32'(data_out), 32'(8'(N)));
    pulse(16'h9000, 1'b0, 8'h00, 8'h90);
    wait_done();
    chk("t5_dropped", 32'(dropped), 32'd1);
    chk("t5_count_after", 32'(code_count), 32'(N));
    rd(16'h9000, 8'h5A, 1'b1);
    chk("t5_new_dout", 32'(data_out), 32'h5A);
    chk("t5_new_ovr", 32'(genie_ovr), 32'd0);
    pulse(16'h8005, 1'b0, 8'h00, 8'hEE);
    wait_done();
    chk("t5_full_overwrite_count", 32'(code_count), 32'(N));
    rd(16'h8005, 8'h00, 1'b1);
    chk("t5_full_overwrite_dout", 32'(data_out), 32'hEE);

    // 6: reset five cycles into SCAN
    pulse(16'h7000, 1'b0, 8'h00, 8'h70);
    repeat (5) tick();
    chk("t6_busy_scanning", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_available", 32'(available), 32'd0);
    chk("t6_count", 32'(code_count), 32'd0);
    chk("t6_dropped", 32'(dropped), 32'd0);
    chk("t6_dout", 32'(data_out), 32'h00);
    reset = 1'b0;
    rd(16'h8000, 8'h3C, 1'b1);
    chk("t6_pass_dout", 32'(data_out), 32'h3C);
    chk("t6_pass_ovr", 32'(genie_ovr), 32'd0);
    repeat (N + 4) tick();
    chk("t6_no_partial", 32'(available), 32'd0);
    rd(16'h7000, 8'h3D, 1'b1);
    chk("t6_aborted_code", 32'(data_out), 32'h3D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
